// File: rtl/traffic_pkg.sv
// Shared phase encoding and default phase durations for the traffic-light sequencer
// and the display stage that consumes its phase/sec_left outputs.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_RED  = 2'd1,
    PH_GRN  = 2'd2,
    PH_YEL  = 2'd3
  } phase_t;

  localparam int DEF_CLK_HZ  = 50_000_000;
  localparam int DEF_RED_SEC = 10;
  localparam int DEF_GRN_SEC = 8;
  localparam int DEF_YEL_SEC = 3;
  localparam int DEF_CNT_W   = 4;

  // Natural rotation RED -> GRN -> YEL -> RED; IDLE only leaves via first_in.
  function automatic phase_t next_phase(input phase_t p);
    case (p)
      PH_RED:  return PH_GRN;
      PH_GRN:  return PH_YEL;
      PH_YEL:  return PH_RED;
      default: return PH_IDLE;
    endcase
  endfunction

  // Lamp pattern packed as {red, yellow, green}.
  function automatic logic [2:0] lamps_of(input phase_t p);
    case (p)
      PH_RED:  return 3'b100;
      PH_GRN:  return 3'b001;
      PH_YEL:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler with synchronous clear; with TRAFFIC_YEL_BLINK_EN defined it
// also flags the half-second point for the yellow blink.
module tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
`ifdef TRAFFIC_YEL_BLINK_EN
  output logic half_tick,
`endif
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_HZ - 1));

`ifdef TRAFFIC_YEL_BLINK_EN
  assign half_tick = (cnt == CW'(CLK_HZ / 2 - 1));
`endif

  // Clear forces count 0 on the entry edge, so the first tick is CLK_HZ cycles later.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/traffic_light_seq.sv
// Timed RED -> GRN -> YEL sequencer with edge-triggered force requests.
// Optional TRAFFIC_YEL_BLINK_EN makes the yellow lamp blink at 1 Hz (half-second toggles).
//
// state   | meaning
// IDLE    | first_in low, all lamps off, sec_left 0
// RED     | red lamp, counting down RED_SEC
// GRN     | green lamp, counting down GRN_SEC
// YEL     | yellow lamp (solid or blinking), counting down YEL_SEC
module traffic_light_seq
  import traffic_pkg::*;
#(
  parameter int CLK_HZ  = DEF_CLK_HZ,
  parameter int RED_SEC = DEF_RED_SEC,
  parameter int GRN_SEC = DEF_GRN_SEC,
  parameter int YEL_SEC = DEF_YEL_SEC,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             first_in,
  input  logic             req_r,
  input  logic             req_y,
  input  logic             req_g,
  output logic             led_r,
  output logic             led_y,
  output logic             led_g,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] sec_left
);

  phase_t     state;
  logic [2:0] req_q;
  logic [2:0] req_now;
  logic [2:0] req_edge;
  logic       tick;
  logic       clear;
  logic       go_idle;
  logic       load;
  phase_t     load_ph;
`ifdef TRAFFIC_YEL_BLINK_EN
  logic       half_tick;
`endif

  function automatic logic [CNT_W-1:0] dur_of(input phase_t p);
    case (p)
      PH_RED:  return CNT_W'(RED_SEC);
      PH_GRN:  return CNT_W'(GRN_SEC);
      PH_YEL:  return CNT_W'(YEL_SEC);
      default: return '0;
    endcase
  endfunction

  assign req_now  = {req_r, req_y, req_g};
  assign req_edge = req_now & ~req_q;
  assign phase    = state;

  assign go_idle = (state != PH_IDLE) && !first_in;

  // Prescaler stays parked in IDLE and restarts on every forced entry; tick-driven
  // entries coincide with the natural wrap so need no explicit clear.
  assign clear = (state == PH_IDLE) || !first_in || (|req_edge);

  tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
`ifdef TRAFFIC_YEL_BLINK_EN
    .half_tick(half_tick),
`endif
    .tick     (tick)
  );

  // Phase-entry decision; request priority r > y > g, and any request beats a tick.
  always_comb begin
    load    = 1'b0;
    load_ph = state;
    if (state == PH_IDLE) begin
      if (first_in) begin
        load    = 1'b1;
        load_ph = PH_RED;
      end
    end else if (first_in) begin
      if (req_edge[2]) begin
        load    = 1'b1;
        load_ph = PH_RED;
      end else if (req_edge[1]) begin
        load    = 1'b1;
        load_ph = PH_YEL;
      end else if (req_edge[0]) begin
        load    = 1'b1;
        load_ph = PH_GRN;
      end else if (tick && (sec_left == CNT_W'(1))) begin
        load    = 1'b1;
        load_ph = next_phase(state);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= PH_IDLE;
      sec_left <= '0;
      led_r    <= 1'b0;
      led_y    <= 1'b0;
      led_g    <= 1'b0;
      req_q    <= '0;
    end else begin
      req_q <= req_now;
      if (go_idle) begin
        state    <= PH_IDLE;
        sec_left <= '0;
        led_r    <= 1'b0;
        led_y    <= 1'b0;
        led_g    <= 1'b0;
      end else if (load) begin
        state                 <= load_ph;
        sec_left              <= dur_of(load_ph);
        {led_r, led_y, led_g} <= lamps_of(load_ph);
      end else if (state != PH_IDLE) begin
        if (tick) begin
          sec_left <= sec_left - CNT_W'(1);
        end
`ifdef TRAFFIC_YEL_BLINK_EN
        if ((state == PH_YEL) && (tick || half_tick)) begin
          led_y <= ~led_y;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_seq.sv
// Directed bench for traffic_light_seq with CLK_HZ=4, RED=3, GRN=2, YEL=1.
module tb_traffic_light_seq;

  logic       clk;
  logic       rst_n;
  logic       first_in;
  logic       req_r;
  logic       req_y;
  logic       req_g;
  logic       led_r;
  logic       led_y;
  logic       led_g;
  logic [1:0] phase;
  logic [3:0] sec_left;

  logic [8:0] obs;
  logic [8:0] e;
  int         errors;
  int         checks;

  traffic_light_seq #(
    .CLK_HZ (4),
    .RED_SEC(3),
    .GRN_SEC(2),
    .YEL_SEC(1),
    .CNT_W  (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .first_in(first_in),
    .req_r   (req_r),
    .req_y   (req_y),
    .req_g   (req_g),
    .led_r   (led_r),
    .led_y   (led_y),
    .led_g   (led_g),
    .phase   (phase),
    .sec_left(sec_left)
  );

  // {phase, sec_left, led_r, led_y, led_g}
  assign obs = {phase, sec_left, led_r, led_y, led_g};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; first_in = 1'b0; req_r = 1'b0; req_y = 1'b0; req_g = 1'b0;
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      checks++;
      if (obs !== 9'h000) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%h want=%h", i, obs, 9'h000);
      end
    end
  endtask

  task automatic test_cycle();
    first_in = 1'b1;
    step(1);
    checks++;
    if (obs !== {2'd1, 4'd3, 3'b100}) begin
      errors++;
      $display("FAIL enter_red got=%h want=%h", obs, {2'd1, 4'd3, 3'b100});
    end
    for (int m = 1; m <= 24; m++) begin
      step(1);
      if (m < 12)      e = {2'd1, 4'(3 - m / 4), 3'b100};
      else if (m < 20) e = {2'd2, 4'(2 - (m - 12) / 4), 3'b001};
      else if (m < 24) begin
`ifdef TRAFFIC_YEL_BLINK_EN
        e = {2'd3, 4'd1, 1'b0, ((m - 20) < 2), 1'b0};
`else
        e = {2'd3, 4'd1, 3'b010};
`endif
      end
      else             e = {2'd1, 4'd3, 3'b100};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL cycle m=%0d got=%h want=%h", m, obs, e);
      end
    end
  endtask

  task automatic test_force_green();
    step(4);
    checks++;
    if (obs !== {2'd1, 4'd2, 3'b100}) begin
      errors++;
      $display("FAIL red_pre_force got=%h want=%h", obs, {2'd1, 4'd2, 3'b100});
    end
    req_g = 1'b1;
    step(1);
    checks++;
    if (obs !== {2'd2, 4'd2, 3'b001}) begin
      errors++;
      $display("FAIL force_grn got=%h want=%h", obs, {2'd2, 4'd2, 3'b001});
    end
    step(4);
    checks++;
    if (obs !== {2'd2, 4'd1, 3'b001}) begin
      errors++;
      $display("FAIL held_no_restart got=%h want=%h", obs, {2'd2, 4'd1, 3'b001});
    end
    req_g = 1'b0;
    step(4);
    checks++;
    if (obs !== {2'd3, 4'd1, 3'b010}) begin
      errors++;
      $display("FAIL grn_to_yel got=%h want=%h", obs, {2'd3, 4'd1, 3'b010});
    end
  endtask

  task automatic test_simultaneous();
    req_r = 1'b1; req_g = 1'b1;
    step(1);
    checks++;
    if (obs !== {2'd1, 4'd3, 3'b100}) begin
      errors++;
      $display("FAIL r_over_g got=%h want=%h", obs, {2'd1, 4'd3, 3'b100});
    end
    req_r = 1'b0; req_g = 1'b0;
    step(1);
    req_y = 1'b1; req_g = 1'b1;
    step(1);
    checks++;
    if (obs !== {2'd3, 4'd1, 3'b010}) begin
      errors++;
      $display("FAIL y_over_g got=%h want=%h", obs, {2'd3, 4'd1, 3'b010});
    end
    req_y = 1'b0; req_g = 1'b0;
    req_r = 1'b1;
    step(1);
    req_r = 1'b0;
  endtask

  task automatic test_req_on_tick();
    // Now at RED entry; tick is consumed on the 4th edge after entry.
    step(3);
    req_y = 1'b1;
    step(1);
    checks++;
    if (obs !== {2'd3, 4'd1, 3'b010}) begin
      errors++;
      $display("FAIL req_beats_tick got=%h want=%h", obs, {2'd3, 4'd1, 3'b010});
    end
    req_y = 1'b0;
    step(3);
    req_y = 1'b1;
    step(1);
    req_y = 1'b0;
    checks++;
    if (obs !== {2'd3, 4'd1, 3'b010}) begin
      errors++;
      $display("FAIL yel_restart got=%h want=%h", obs, {2'd3, 4'd1, 3'b010});
    end
    step(3);
    checks++;
    if (phase !== 2'd3) begin
      errors++;
      $display("FAIL yel_restart_hold got=%0d want=%0d", phase, 3);
    end
    step(1);
    checks++;
    if (obs !== {2'd1, 4'd3, 3'b100}) begin
      errors++;
      $display("FAIL yel_restart_exit got=%h want=%h", obs, {2'd1, 4'd3, 3'b100});
    end
  endtask

  task automatic test_first_in_drop();
    req_g = 1'b1;
    step(1);
    req_g = 1'b0;
    checks++;
    if (obs !== {2'd2, 4'd2, 3'b001}) begin
      errors++;
      $display("FAIL drop_setup got=%h want=%h", obs, {2'd2, 4'd2, 3'b001});
    end
    step(2);
    first_in = 1'b0;
    step(1);
    checks++;
    if (obs !== 9'h000) begin
      errors++;
      $display("FAIL drop_idle got=%h want=%h", obs, 9'h000);
    end
    req_r = 1'b1;
    step(1);
    checks++;
    if (obs !== 9'h000) begin
      errors++;
      $display("FAIL idle_ignores_req got=%h want=%h", obs, 9'h000);
    end
    req_r = 1'b0;
    first_in = 1'b1;
    for (int m = 0; m <= 4; m++) begin
      step(1);
      e = {2'd1, (m < 4) ? 4'd3 : 4'd2, 3'b100};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reenter m=%0d got=%h want=%h", m, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0; req_g = 1'b1;
    step(1);
    checks++;
    if (obs !== 9'h000) begin
      errors++;
      $display("FAIL reset_mid got=%h want=%h", obs, 9'h000);
    end
    rst_n = 1'b1; req_g = 1'b0;
    step(1);
    checks++;
    if (obs !== {2'd1, 4'd3, 3'b100}) begin
      errors++;
      $display("FAIL after_reset got=%h want=%h", obs, {2'd1, 4'd3, 3'b100});
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_cycle();
    test_force_green();
    test_simultaneous();
    test_req_on_tick();
    test_first_in_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
